// File: rtl/cfi_landing_pad_checker.sv
`default_nettype none
// ============================================================================
// Module   : cfi_landing_pad_checker
// Brief    : Commit-stage CFI monitor; a qualifying JALR must be followed by a
//            landing-pad marker within WINDOW committed instructions.
// Revision : 1.0
// ============================================================================

package riscv;
    localparam int unsigned XLEN = 64;
    localparam logic [XLEN-1:0] BREAKPOINT = 64'd3;
endpackage

package ariane_pkg;
    typedef enum logic [3:0] {
        ADD, SUB, XORL, ORL, ANDL, SLTS, JALR, BEQ, LD, SD
    } fu_op;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] pc;
        fu_op        op;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [63:0] result;
        exception_t  ex;
    } scoreboard_entry_t;
endpackage

module cfi_landing_pad_checker
    import ariane_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter fu_op        LP_OP           = ADD,
    parameter logic [4:0]  LP_RD           = 5'd0,
    parameter logic [4:0]  LP_RS1          = 5'd0,
    parameter logic [4:0]  LP_IMM          = 5'd1,
    parameter int unsigned WINDOW          = 1,
    parameter int unsigned TRIG_MODE       = 0,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic                                      en_i,
    input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_instr_i,
    output exception_t                                exception_o,
    output logic [CNT_WIDTH-1:0]                      violation_cnt_o,
    output logic                                      armed_o
);

    localparam logic [3:0]  c_window = 4'(WINDOW);
    localparam int unsigned c_nv_w   = $clog2(NR_COMMIT_PORTS + 1);

    logic                       r_armed;
    logic [3:0]                 r_rem;
    exception_t                 r_exc;
    logic [CNT_WIDTH-1:0]       r_cnt;

    logic                       w_armed;
    logic [3:0]                 w_rem;
    logic [NR_COMMIT_PORTS-1:0] w_viol;
    logic [c_nv_w-1:0]          w_nviol;
    logic [63:0]                w_tval;
    logic                       w_found;
    logic [CNT_WIDTH:0]         w_cnt_sum;
    logic                       w_unused;

    // Only a few fields of each entry matter; fold the rest into one sink.
    assign w_unused = ^commit_instr_i;

    function automatic logic f_is_lp(input scoreboard_entry_t e);
        return (e.op == LP_OP) && (e.rd[4:0] == LP_RD) &&
               (e.rs1[4:0] == LP_RS1) && (e.result[4:0] == LP_IMM);
    endfunction

    function automatic logic f_is_trig(input scoreboard_entry_t e);
        if (TRIG_MODE != 0) begin
            return (e.op == JALR);
        end
        return (e.op == JALR) && (e.rd[4:0] == 5'd0) && (e.rs1[4:0] == 5'd1);
    endfunction

    // Slots are walked in program order; each sees the state left by the previous one.
    always_comb begin
        w_armed = r_armed;
        w_rem   = r_rem;
        w_viol  = '0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (commit_ack_i[i]) begin
                if (commit_instr_i[i].ex.valid) begin
                    w_armed = 1'b0;
                    w_rem   = 4'd0;
                end else begin
                    if (w_armed) begin
                        if (f_is_lp(commit_instr_i[i])) begin
                            w_armed = 1'b0;
                            w_rem   = 4'd0;
                        end else begin
                            w_rem = w_rem - 4'd1;
                            if (w_rem == 4'd0) begin
                                w_viol[i] = 1'b1;
                                w_armed   = 1'b0;
                            end
                        end
                    end
                    // A trigger re-arms even on the slot that just closed a window.
                    if (f_is_trig(commit_instr_i[i])) begin
                        w_armed = 1'b1;
                        w_rem   = c_window;
                    end
                end
            end
        end
        if (!en_i || flush_i) begin
            w_armed = 1'b0;
            w_rem   = 4'd0;
            w_viol  = '0;
        end
    end

    always_comb begin
        w_nviol = '0;
        w_tval  = '0;
        w_found = 1'b0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (w_viol[i]) begin
                w_nviol = w_nviol + c_nv_w'(1);
                if (!w_found) begin
                    w_tval  = commit_instr_i[i].pc;
                    w_found = 1'b1;
                end
            end
        end
    end

    // Extra top bit catches a carry out, which means the counter must pin at all-ones.
    assign w_cnt_sum = {1'b0, r_cnt} + (CNT_WIDTH + 1)'(w_nviol);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_armed <= 1'b0;
            r_rem   <= 4'd0;
            r_exc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_armed     <= w_armed;
            r_rem       <= w_rem;
            r_exc.valid <= w_found;
            r_exc.cause <= w_found ? riscv::BREAKPOINT : 64'd0;
            r_exc.tval  <= w_tval;
            r_cnt       <= w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];
        end
    end

    assign exception_o     = r_exc;
    assign violation_cnt_o = r_cnt;
    assign armed_o         = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_cfi_landing_pad_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfi_landing_pad_checker
// Brief    : Two checker instances (4-port/W1/return-only and 2-port/W3/any-JALR)
//            driven by shared directed and random commit streams.
// Revision : 1.0
// ============================================================================
module tb_cfi_landing_pad_checker;
    import ariane_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    flush;
    logic                    en;
    logic [3:0]              ack;
    scoreboard_entry_t [3:0] instr;
    logic [1:0]              ack_b;
    scoreboard_entry_t [1:0] instr_b;

    exception_t  exc_a, exc_b;
    logic [15:0] cnt_a, cnt_b;
    logic        armed_a, armed_b;

    assign ack_b   = ack[1:0];
    assign instr_b = instr[1:0];

    cfi_landing_pad_checker #(
        .NR_COMMIT_PORTS(4), .WINDOW(1), .TRIG_MODE(0)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .en_i(en),
        .commit_ack_i(ack), .commit_instr_i(instr),
        .exception_o(exc_a), .violation_cnt_o(cnt_a), .armed_o(armed_a)
    );

    cfi_landing_pad_checker #(
        .NR_COMMIT_PORTS(2), .WINDOW(3), .TRIG_MODE(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .en_i(en),
        .commit_ack_i(ack_b), .commit_instr_i(instr_b),
        .exception_o(exc_b), .violation_cnt_o(cnt_b), .armed_o(armed_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: position of the pending trigger in the committed stream (-1 = none).
    longint      m_pos   [2];
    longint      m_idx   [2];
    int          m_cnt   [2];
    logic        m_valid [2];
    logic [63:0] m_tval  [2];
    int          c_np    [2] = '{4, 2};
    int          c_win   [2] = '{1, 3};
    int          c_tm    [2] = '{0, 1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_lp(input scoreboard_entry_t e);
        return e.op == ADD && e.rd[4:0] == 5'd0 && e.rs1[4:0] == 5'd0 && e.result[4:0] == 5'd1;
    endfunction

    function automatic bit is_trig(input scoreboard_entry_t e, input int tm);
        return e.op == JALR && (tm == 1 || (e.rd[4:0] == 5'd0 && e.rs1[4:0] == 5'd1));
    endfunction

    task automatic model(input int d);
        int nv;
        scoreboard_entry_t e;
        m_valid[d] = 1'b0;
        m_tval[d]  = 64'd0;
        if (!rst_n) begin
            m_pos[d] = -1;
            m_idx[d] = 0;
            m_cnt[d] = 0;
            return;
        end
        if (!en || flush) begin
            m_pos[d] = -1;
            return;
        end
        nv = 0;
        for (int s = 0; s < c_np[d]; s++) begin
            if (ack[s]) begin
                m_idx[d]++;
                e = instr[s];
                if (e.ex.valid) begin
                    m_pos[d] = -1;
                end else begin
                    if (m_pos[d] >= 0) begin
                        if (is_lp(e)) begin
                            m_pos[d] = -1;
                        end else if (m_idx[d] - m_pos[d] == longint'(c_win[d])) begin
                            if (!m_valid[d]) begin
                                m_valid[d] = 1'b1;
                                m_tval[d]  = e.pc;
                            end
                            nv++;
                            m_pos[d] = -1;
                        end
                    end
                    if (is_trig(e, c_tm[d])) m_pos[d] = m_idx[d];
                end
            end
        end
        m_cnt[d] = (m_cnt[d] + nv > 65535) ? 65535 : m_cnt[d] + nv;
    endtask

    task automatic check_all();
        check("a_valid", 64'(exc_a.valid), 64'(m_valid[0]));
        check("a_cause", exc_a.cause, m_valid[0] ? 64'd3 : 64'd0);
        check("a_tval",  exc_a.tval,  m_tval[0]);
        check("a_cnt",   64'(cnt_a),  64'(m_cnt[0]));
        check("a_armed", 64'(armed_a), 64'(m_pos[0] >= 0));
        check("b_valid", 64'(exc_b.valid), 64'(m_valid[1]));
        check("b_cause", exc_b.cause, m_valid[1] ? 64'd3 : 64'd0);
        check("b_tval",  exc_b.tval,  m_tval[1]);
        check("b_cnt",   64'(cnt_b),  64'(m_cnt[1]));
        check("b_armed", 64'(armed_b), 64'(m_pos[1] >= 0));
    endtask

    task automatic step();
        model(0);
        model(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        ack = 4'd0;
        step();
    endtask

    function automatic scoreboard_entry_t mk(input fu_op op, input logic [5:0] rd,
                                             input logic [5:0] rs1, input logic [63:0] res,
                                             input logic [63:0] pc);
        scoreboard_entry_t e;
        e        = '0;
        e.op     = op;
        e.rd     = rd;
        e.rs1    = rs1;
        e.result = res;
        e.pc     = pc;
        return e;
    endfunction

    function automatic scoreboard_entry_t rand_instr(input logic [63:0] pc);
        scoreboard_entry_t e;
        int k;
        k = $urandom_range(0, 11);
        e = mk(ADD, 6'($urandom_range(0, 31)), 6'($urandom_range(0, 31)), {$urandom(), $urandom()}, pc);
        e.rs2 = 6'($urandom_range(0, 63));
        case (k)
            0, 1, 2: begin e.op = JALR; e.rd = 6'd0; e.rs1 = 6'd1; end
            3:       e.op = JALR;
            4, 5:    begin
                e.rd          = {1'($urandom_range(0, 1)), 5'd0};
                e.rs1         = {1'($urandom_range(0, 1)), 5'd0};
                e.result[4:0] = 5'd1;
            end
            6:       begin e.rd = 6'd0; e.rs1 = 6'd0; end
            7:       e.op = ADD;
            8, 9:    e.op = fu_op'(4'($urandom_range(1, 9)));
            10:      begin e.op = JALR; e.rd = 6'd0; e.rs1 = 6'd1; e.ex.valid = 1'b1; end
            default: begin e.rd = 6'd0; e.rs1 = 6'd0; e.result[4:0] = 5'd1; e.ex.valid = 1'b1; end
        endcase
        return e;
    endfunction

    logic [15:0] base_a;
    logic [15:0] base_b;
    int          guard;
    logic [63:0] pc;

    initial begin
        rst_n = 1'b0; flush = 1'b0; en = 1'b1; ack = 4'd0; instr = '0;
        for (int i = 0; i < 3; i++) step();
        check("rst_a_cnt", 64'(cnt_a), 64'd0);
        rst_n = 1'b1;

        // Return and landing pad in the same cycle.
        instr[0] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h1000);
        instr[1] = mk(ADD, 6'd0, 6'd0, 64'd1, 64'h1004);
        ack = 4'b0011;
        step();
        check("t1_armed", 64'(armed_a), 64'd0);
        check("t1_valid", 64'(exc_a.valid), 64'd0);
        check("t1_cnt",   64'(cnt_a), 64'd0);

        // Return on slot1, next commit is not a landing pad.
        instr[0] = mk(ADD, 6'd1, 6'd0, 64'd5, 64'h8000_003C);
        instr[1] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h8000_0040);
        ack = 4'b0011;
        step();
        check("t2_armed", 64'(armed_a), 64'd1);
        instr[0] = mk(ADD, 6'd1, 6'd0, 64'd5, 64'h8000_0044);
        ack = 4'b0001;
        step();
        check("t2_valid", 64'(exc_a.valid), 64'd1);
        check("t2_cause", exc_a.cause, 64'd3);
        check("t2_tval",  exc_a.tval, 64'h8000_0044);
        check("t2_cnt",   64'(cnt_a), 64'd1);
        idle();
        check("t2_pulse", 64'(exc_a.valid), 64'd0);

        // WINDOW=3 instance: landing pad arrives as the third commit after idles.
        flush = 1'b1; idle(); flush = 1'b0;
        base_b = cnt_b;
        instr[0] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h2000);
        ack = 4'b0001; step();
        idle(); idle();
        check("t3_armed_idle", 64'(armed_b), 64'd1);
        instr[0] = mk(SUB, 6'd3, 6'd4, 64'd9, 64'h2010); ack = 4'b0001; step();
        instr[0] = mk(ADD, 6'd3, 6'd4, 64'd9, 64'h2014); ack = 4'b0001; step();
        check("t3_armed_pre", 64'(armed_b), 64'd1);
        instr[0] = mk(ADD, 6'd0, 6'd0, 64'd1, 64'h2018); ack = 4'b0001; step();
        check("t3_armed_post", 64'(armed_b), 64'd0);
        idle();
        check("t3_valid", 64'(exc_b.valid), 64'd0);
        check("t3_cnt",   64'(cnt_b), 64'(base_b));

        // Four ports, two violations in one cycle.
        base_a = cnt_a;
        instr[0] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h3000);
        instr[1] = mk(ADD, 6'd5, 6'd5, 64'd7, 64'h3004);
        instr[2] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h3008);
        instr[3] = mk(ADD, 6'd6, 6'd6, 64'd7, 64'h300C);
        ack = 4'b1111;
        step();
        check("t4_valid", 64'(exc_a.valid), 64'd1);
        check("t4_tval",  exc_a.tval, 64'h3004);
        check("t4_cnt",   64'(cnt_a), 64'(base_a + 16'd2));
        idle();
        check("t4_pulse", 64'(exc_a.valid), 64'd0);

        // Non-return JALR: triggers only the any-JALR instance.
        flush = 1'b1; idle(); flush = 1'b0;
        instr[0] = mk(JALR, 6'd5, 6'd6, 64'd0, 64'h4000); ack = 4'b0001; step();
        for (int i = 0; i < 3; i++) begin
            instr[0] = mk(SUB, 6'd7, 6'd8, 64'd0, 64'h4004 + 64'(4 * i)); ack = 4'b0001; step();
        end
        check("t5_b_valid", 64'(exc_b.valid), 64'd1);
        check("t5_b_tval",  exc_b.tval, 64'h400C);
        check("t5_a_valid", 64'(exc_a.valid), 64'd0);

        // Flush and disable both swallow the would-be violation.
        instr[0] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h5000); ack = 4'b0001; step();
        flush = 1'b1;
        instr[0] = mk(SUB, 6'd7, 6'd8, 64'd0, 64'h5004); step();
        flush = 1'b0;
        check("t6_armed", 64'(armed_a), 64'd0);
        idle();
        check("t6_valid", 64'(exc_a.valid), 64'd0);
        instr[0] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h5100); ack = 4'b0001; step();
        en = 1'b0;
        instr[0] = mk(SUB, 6'd7, 6'd8, 64'd0, 64'h5104); step();
        en = 1'b1;
        check("t6_en_armed", 64'(armed_a), 64'd0);
        idle();
        check("t6_en_valid", 64'(exc_a.valid), 64'd0);

        // Random commit streams.
        pc = 64'h8000_0000;
        for (int c = 0; c < 3000; c++) begin
            int len;
            flush = ($urandom_range(0, 19) == 0);
            en    = ($urandom_range(0, 24) != 0);
            len   = $urandom_range(0, 4);
            ack   = 4'((1 << len) - 1);
            for (int s = 0; s < 4; s++) begin
                instr[s] = rand_instr(pc);
                pc = pc + 64'd4;
            end
            step();
        end

        // Drive the counter into saturation, then past it.
        flush = 1'b0; en = 1'b1;
        guard = 0;
        while (m_cnt[0] < 65535 && guard < 40000) begin
            instr[0] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h6000);
            instr[1] = mk(ADD, 6'd5, 6'd5, 64'd0, 64'h6004);
            instr[2] = mk(JALR, 6'd0, 6'd1, 64'd0, 64'h6008);
            instr[3] = mk(ADD, 6'd6, 6'd6, 64'd0, 64'h600C);
            ack = 4'b1111;
            step();
            guard++;
        end
        check("sat_reached", 64'(guard < 40000), 64'd1);
        step();
        step();
        check("sat_cnt", 64'(cnt_a), 64'hFFFF);
        check("sat_valid", 64'(exc_a.valid), 64'd1);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
